// File: rtl/pong_pkg.sv
// Shared constants for the pong input-conditioning path: button indices
// into the four-bit button vectors and the button count.
package pong_pkg;

    localparam int NUM_BTN   = 4;

    localparam int BTN_P1_UP = 0;
    localparam int BTN_P1_DN = 1;
    localparam int BTN_P2_UP = 2;
    localparam int BTN_P2_DN = 3;

endpackage : pong_pkg

// File: rtl/pong_debounce.sv
// One-bit button conditioner: two-flop synchroniser, consecutive-difference
// debounce counter, debounced level and a one-cycle rising-edge pulse.
module pong_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_db,
    output logic btn_press
);

    // Count value on which the stable level is allowed to flip.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_press;

    // Two-flop chain bringing the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // Stable level flips only after DEBOUNCE_CYCLES consecutive differing
    // samples; any sample matching the stable level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_db    <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign btn_db    = r_db;
    assign btn_press = r_press;

endmodule : pong_debounce

// File: rtl/pong_input_ctrl.sv
// Input conditioning ahead of the pong core: debounces the four player
// buttons and moves two saturating paddle positions once per frame.
module pong_input_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int PY_W            = 9,
    parameter int PADDLE_MAX      = 400,
    parameter int PADDLE_STEP     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTN-1:0]  btn_in,
    input  logic                frame_tick,
    output logic [NUM_BTN-1:0]  btn_db,
    output logic [NUM_BTN-1:0]  btn_press,
    output logic [PY_W-1:0]     paddle1_y,
    output logic [PY_W-1:0]     paddle2_y
);

    localparam logic [PY_W-1:0] PADDLE_RST = PY_W'(PADDLE_MAX / 2);
    localparam logic [PY_W:0]   W_STEP     = (PY_W+1)'(PADDLE_STEP);
    localparam logic [PY_W:0]   W_MAX      = (PY_W+1)'(PADDLE_MAX);

    logic [NUM_BTN-1:0] w_db;
    logic [NUM_BTN-1:0] w_press;
    logic [PY_W-1:0]    r_paddle1;
    logic [PY_W-1:0]    r_paddle2;

    // Next paddle position: one step up or down, clamped to [0, PADDLE_MAX].
    // The extra bit keeps y+step from wrapping before the clamp compare.
    function automatic logic [PY_W-1:0] paddle_next(
        input logic [PY_W-1:0] y,
        input logic            up,
        input logic            dn
    );
        logic [PY_W:0] w_y;
        logic [PY_W:0] w_sum;
        w_y   = {1'b0, y};
        w_sum = w_y + W_STEP;
        paddle_next = y;
        if (up && !dn) begin
            paddle_next = (w_y < W_STEP) ? '0 : PY_W'(w_y - W_STEP);
        end else if (dn && !up) begin
            paddle_next = (w_sum > W_MAX) ? PY_W'(W_MAX) : PY_W'(w_sum);
        end
    endfunction

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        pong_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (btn_in[gi]),
            .btn_db    (w_db[gi]),
            .btn_press (w_press[gi])
        );
    end

    // Paddles move only on frame_tick, using the registered (pre-update)
    // debounced levels, so a level changing on the same edge is not seen yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_paddle1 <= PADDLE_RST;
            r_paddle2 <= PADDLE_RST;
        end else if (frame_tick) begin
            r_paddle1 <= paddle_next(r_paddle1, w_db[BTN_P1_UP], w_db[BTN_P1_DN]);
            r_paddle2 <= paddle_next(r_paddle2, w_db[BTN_P2_UP], w_db[BTN_P2_DN]);
        end
    end

    assign btn_db    = w_db;
    assign btn_press = w_press;
    assign paddle1_y = r_paddle1;
    assign paddle2_y = r_paddle2;

endmodule : pong_input_ctrl
